// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, bubble
// encoding, fetch FSM states and the BZ branch-target arithmetic.
package fetch_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;

  localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // pc + 1 + sext(imm6); callers truncate to their PC width, which gives
  // the required wrap-around.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [5:0]  imm6);
    return pc + 32'd1 + {{26{imm6[5]}}, imm6};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction (and its PC) that came back
// from memory while decode was stalled.
module if_skid_buf #(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [15:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [15:0]     instr_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q;
  logic [15:0]     instr_q;
  logic [PC_W-1:0] pc_q;

  // Clear wins over load; the two never coincide in normal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues one outstanding imem request at a time and
// fills the IF/ID register, honouring decode stall and taken-branch redirect.
module instr_fetch_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [5:0]      branch_offset_imm,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [15:0]     imem_rsp_data,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid
);
  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic            req_valid_q, drop_q, if_valid_q;
  logic [PC_W-1:0] fetch_pc_q, req_pc_q, if_pc_q, target_pc;
  logic [15:0]     if_instr_q;

  logic            accept, redirect, deliver_rsp, deliver_buf;
  logic            buf_load, buf_clear, buf_valid;
  logic [15:0]     buf_instr;
  logic [PC_W-1:0] buf_pc;

  // req_valid_q is only ever high in S_REQ, so it alone qualifies the handshake.
  assign accept    = req_valid_q & imem_req_ready;
  assign redirect  = branch_taken & ~stall;
  assign target_pc = PC_W'(branch_target(32'(if_pc_q), branch_offset_imm));
  assign buf_clear = redirect | deliver_buf;

  if_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imem_rsp_data),
    .pc_i    (req_pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // Next state and where (if anywhere) the returning instruction goes.
  always_comb begin
    state_d     = state_q;
    deliver_rsp = 1'b0;
    deliver_buf = 1'b0;
    buf_load    = 1'b0;
    case (state_q)
      S_REQ: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect) begin
            state_d = S_REQ;
          end else if (!stall) begin
            state_d     = S_REQ;
            deliver_rsp = 1'b1;
          end else begin
            state_d  = S_HOLD;
            buf_load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          state_d     = S_REQ;
          deliver_buf = ~redirect & buf_valid;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM state, PCs, squash flag and IF/ID register; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      req_valid_q <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == S_REQ);

      if (accept) begin
        req_pc_q   <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
      if (redirect) fetch_pc_q <= target_pc;

      // A response always ends the squash window; a redirect with a request
      // in flight (or just accepted) opens one.
      if (state_q == S_WAIT && imem_rsp_valid) drop_q <= 1'b0;
      else if (redirect && (accept || state_q == S_WAIT)) drop_q <= 1'b1;

      if (deliver_rsp) begin
        if_instr_q <= imem_rsp_data;
        if_pc_q    <= req_pc_q;
        if_valid_q <= 1'b1;
      end else if (deliver_buf) begin
        if_instr_q <= buf_instr;
        if_pc_q    <= buf_pc;
        if_valid_q <= 1'b1;
      end else if (!stall) begin
        if_instr_q <= NOP_INSTR;
        if_valid_q <= 1'b0;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = fetch_pc_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory model plus a program-order
// scoreboard of instructions decode should see, checked by a separate monitor.
module tb_instr_fetch_unit;

  localparam int          PC_W = 16;
  localparam logic [15:0] NOP  = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } item_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic [5:0]      imm = '0;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic [PC_W-1:0] addr;
  logic            rsp_valid = 1'b0;
  logic [15:0]     rsp_data = '0;
  logic [15:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            if_valid;

  item_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  logic [15:0] last_pc = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(16'd0), .NOP_INSTR(NOP)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_offset_imm (imm),
    .imem_req_valid    (req_valid),
    .imem_req_ready    (req_ready),
    .imem_addr         (addr),
    .imem_rsp_valid    (rsp_valid),
    .imem_rsp_data     (rsp_data),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_valid          (if_valid)
  );

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a == 16'd0) ? 16'h1042 : 16'h1000 + a;
  endfunction

  // Branch target from plain integer arithmetic, wrapped to 16 bits.
  function automatic logic [15:0] tgt(input logic [15:0] pc, input logic [5:0] off6);
    int off;
    off = off6[5] ? int'(off6) - 64 : int'(off6);
    return 16'(int'(pc) + 1 + off);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares IF/ID after every edge against the scoreboard.
  initial begin
    logic        ev;
    logic [15:0] ei, ep;
    item_t       it;
    ev = 1'b0; ei = NOP; ep = '0;
    @(negedge rst);
    forever begin
      @(posedge clk);
      #2;
      if (stall) begin
        chk("hold_valid", if_valid, ev);
        chk("hold_instr", if_instr, ei);
        if (ev) chk("hold_pc", if_pc, ep);
      end else if (branch_taken) begin
        chk("branch_bubble_valid", if_valid, 0);
        chk("branch_bubble_instr", if_instr, NOP);
        ev = 1'b0; ei = NOP;
      end else if (if_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_delivery: got pc %0h expected none at %0t", if_pc, $time);
        end else begin
          it = exp_q.pop_front();
          chk("deliv_pc", if_pc, it.pc);
          chk("deliv_instr", if_instr, it.instr);
          last_pc = it.pc;
          n_deliv++;
          ev = 1'b1; ei = it.instr; ep = it.pc;
        end
      end else begin
        chk("bubble_instr", if_instr, NOP);
        ev = 1'b0; ei = NOP;
      end
    end
  end

  // Stimulus, memory model and program-order predictor.
  initial begin
    bit          mem_busy, prev_wait, prev_redir, accept, redir;
    int          mem_cnt, mem_epoch, epoch, p_ready, p_stall, p_br, max_lat;
    logic [15:0] mem_addr, exp_fetch, prev_addr, prev_tgt, tgt_pc;
    item_t       it;
    mem_busy = 0; prev_wait = 0; prev_redir = 0; mem_cnt = 0; mem_epoch = 0;
    epoch = 0; mem_addr = '0; exp_fetch = '0; prev_addr = '0; prev_tgt = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, NOP);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", req_valid, 1);
    chk("first_req_addr", addr, 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc < 300 || cyc >= 3800) begin
        p_ready = 100; p_stall = 0; p_br = 0; max_lat = 1;
      end else begin
        p_ready = 70; p_stall = 25; p_br = 15; max_lat = 3;
      end

      // An unaccepted request must stay put, unless a redirect retargeted it.
      if (prev_wait) begin
        chk("req_held_valid", req_valid, 1);
        chk("req_held_addr", addr, prev_redir ? prev_tgt : prev_addr);
      end

      rsp_valid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = rom(mem_addr);
          mem_busy  = 0;
          chk("no_req_during_rsp", req_valid, 0);
          if (mem_epoch == epoch) begin
            it.pc = mem_addr; it.instr = rom(mem_addr);
            exp_q.push_back(it);
          end
        end
      end else begin
        rsp_data = 16'($urandom);
      end

      stall        = ($urandom_range(99) < p_stall);
      branch_taken = if_valid && ($urandom_range(99) < p_br);
      imm          = 6'($urandom);
      req_ready    = ($urandom_range(99) < p_ready);
      accept       = req_valid && req_ready;
      redir        = branch_taken && !stall;
      tgt_pc       = tgt(last_pc, imm);

      if (accept) begin
        chk("req_addr", addr, exp_fetch);
        chk("single_outstanding", mem_busy, 0);
        mem_busy  = 1;
        mem_cnt   = $urandom_range(max_lat, 1);
        mem_addr  = addr;
        mem_epoch = epoch;
        exp_fetch = exp_fetch + 16'd1;
      end
      if (redir) begin
        exp_fetch = tgt_pc;
        epoch++;
        exp_q.delete();
      end

      prev_wait  = req_valid && !req_ready;
      prev_addr  = addr;
      prev_redir = redir;
      prev_tgt   = tgt_pc;
      @(negedge clk);
    end

    chk("deliveries_made", (n_deliv >= 200), 1);
    chk("drain_queue", (exp_q.size() <= 1), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 16-bit pipeline. It is the producer side of the IF/ID interface.
- Owns the word-addressed PC and issues single-outstanding requests to instruction memory.
- Registers the fetched instruction and its PC into the IF/ID pipeline register.
- Honours the decode stage's stall, branch_taken and branch_offset_imm signals: holds on stall, redirects and squashes on a taken branch.

Parameters:
PC_W, 16, PC / instruction-address width in words
RESET_PC, 0, PC fetched first after reset
NOP_INSTR, 16'h0000, bubble encoding (opcode 0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  decode stage hold request; IF/ID contents must not change
branch_taken  in  1  decode has a taken BZ sitting in IF/ID
branch_offset_imm  in  6  signed word offset of that BZ
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  PC_W  fetch word address
imem_rsp_valid  in  1  response data valid (one pulse per accepted request, in order)
imem_rsp_data  in  16  fetched instruction
if_instr  out  16  IF/ID instruction register (decode stage input_instr)
if_pc  out  PC_W  PC of if_instr
if_valid  out  1  if_instr is a real instruction (0 = bubble)

Behaviour:
- Reset (async): fetch_pc=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_valid=0, buffer empty, drop=0, FSM=S_REQ.
  - imem_req_valid=0 while rst is high, then 1 from the first clk edge after release.
  - Memory is reset together with this block; no stale response survives reset.
- FSM states: S_REQ, S_WAIT, S_HOLD.
  - S_REQ:
    - Drive imem_req_valid=1 and imem_addr=fetch_pc. Both stay stable until req_ready.
    - On valid&ready: go to S_WAIT and set fetch_pc=fetch_pc+1 (wraps mod 2^PC_W).
  - S_WAIT:
    - imem_req_valid=0. Wait for rsp_valid.
    - If drop=1: discard the data, clear drop, go to S_REQ.
    - Else if stall=0: load if_instr=rsp_data, if_pc=addr of that request, if_valid=1, go to S_REQ.
    - Else (stall=1): capture into the skid buffer, go to S_HOLD.
  - S_HOLD:
    - imem_req_valid=0.
    - When stall=0: move the buffer into IF/ID (if_valid=1), empty the buffer, go to S_REQ.
- No IF/ID update this cycle (stall=0, no redirect, nothing delivered): if_instr=NOP_INSTR, if_valid=0.
- Peak throughput: one instruction per 2 cycles.
  - A new request is never issued in the cycle a response arrives.
  - There is no combinational path from the imem_rsp_* inputs to the imem_req_* outputs.
- stall=1: if_instr, if_pc and if_valid hold. branch_taken is ignored while stall=1.
- Redirect (branch_taken & !stall), highest priority after rst:
  - target = if_pc + 1 + sext(branch_offset_imm), computed in PC_W bits and wrapping.
  - Set fetch_pc=target.
  - IF/ID gets NOP_INSTR with if_valid=0, so exactly one bubble follows the branch.
  - Skid buffer is cleared.
  - In S_HOLD: go to S_REQ.
  - In S_REQ with the request not yet accepted: retarget imem_addr next cycle. This is the only case where the address changes while valid is high and not accepted.
  - In S_REQ with the request accepted this cycle: go to S_WAIT with drop=1.
  - In S_WAIT: set drop=1.
  - Redirect coincident with rsp_valid in S_WAIT: that response is discarded and the FSM goes to S_REQ.
- A request once accepted always completes; at most one request is outstanding.

Decomposition:
- Shared package fetch_pkg holds:
  - opcode constants (NOP=0, ADDI=9, LD=10, ST=11, BZ=12);
  - NOP_INSTR;
  - the FSM state enum;
  - the branch-target function (pc, imm6) -> pc+1+sext.
- One natural sub-module: if_skid_buf, a one-entry instruction+PC holding register with load/clear/valid.

Test Plan:
- Reset: check req_valid=0 during rst, then req at addr 0. Memory with ready=1 and 1-cycle response, instr 16'h1042 at addr 0 -> if_instr=16'h1042, if_pc=0, if_valid=1 on the cycle after the response.
- Straight line: ROM addr n holds 16'h1000+n, 6 fetches -> if_pc sequence 0..5, each valid for 1 cycle with a bubble between. No skips or duplicates.
- Backpressure: imem_req_ready low 3 cycles in S_REQ at addr 2 -> imem_addr=2 and req_valid=1 held all 4 cycles; exactly one request issued.
- Stall with response in flight: stall=1 for 4 cycles covering rsp of addr 3 -> IF/ID frozen, then instr@3 appears the cycle stall drops. Exactly once; the next request is addr 4.
- Branch: BZ in IF/ID at if_pc=5, imm=6'h3E (-2), branch_taken=1, stall=0 -> bubble next cycle, next accepted request addr=4.
- Branch with request outstanding: redirect to 20 while in S_WAIT for addr 7 -> addr-7 data never reaches if_instr; next request addr=20.
